instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL provide parameter AW, default 4, instruction address width.
REQ-002 SHALL provide parameter IW, default 8, instruction word width.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port imem_addr  output  AW  address driven to the combinational instruction memory.
REQ-006 SHALL provide port imem_data  input  IW  instruction returned by the memory in the same cycle.
REQ-007 SHALL provide port out_valid  output  1  decoded instruction is presented downstream.
REQ-008 SHALL provide port out_ready  input  1  downstream accepts the presented instruction.
REQ-009 SHALL provide port out_pc  output  AW  address of the presented instruction.
REQ-010 SHALL provide port out_op  output  2  opcode, ir[7:6] (00 add, 01 sub, 11 branch-if-zero).
REQ-011 SHALL provide port out_ra, out_rb, out_rd  output  2 each  ir[5:4], ir[3:2], ir[1:0].
REQ-012 SHALL provide port out_target  output  AW  branch target, ir[3:0].
REQ-013 SHALL provide port br_taken  input  1  execute-stage redirect strobe.
REQ-014 SHALL provide port br_target  input  AW  redirect address.
REQ-015 SHALL provide port halted  output  1  fetch stopped on illegal opcode.

Function
REQ-016 SHALL drive imem_addr combinationally from the internal program counter pc.
REQ-017 SHALL implement states FETCH and HALT; reset enters FETCH.
REQ-018 SHALL, in FETCH when out_valid=0 or (out_valid=1 and out_ready=1) and br_taken=0, load ir<=imem_data, out_pc<=pc, out_valid<=1, pc<=pc+1 at the clock edge.
REQ-019 SHALL, when out_valid=1 and out_ready=0 and br_taken=0, hold ir, out_pc, pc and out_valid unchanged (no instruction dropped or duplicated).
REQ-020 SHALL wrap pc from 4'hF to 4'h0 modulo 2^AW with no flag.
REQ-021 SHALL, on br_taken=1 in FETCH, set pc<=br_target and out_valid<=0 at the edge, regardless of out_ready or stall; redirect has highest priority.
REQ-022 SHALL produce the first instruction at the redirect target with out_valid=1 one cycle after the redirect edge (one-bubble penalty).
REQ-023 SHALL derive out_op, out_ra, out_rb, out_rd, out_target combinationally from ir; valid only while out_valid=1.
REQ-024 SHALL treat opcode 10 per REQ-031/REQ-032.
REQ-025 SHALL, in HALT, keep out_valid=0, freeze pc, ignore br_taken and out_ready; exit only via rst.

Reset
REQ-026 SHALL, while rst=1, force pc=0, ir=0, out_pc=0, out_valid=0, halted=0, state=FETCH, independent of clk.
REQ-027 SHALL, on reset assertion mid-stall or mid-redirect, discard the in-flight instruction and pending redirect.
REQ-028 SHALL present address 0 on imem_addr during reset and fetch address 0 on the first edge after release.

Configuration
REQ-029 SHALL use macro FETCH_ILLEGAL_HALT_EN to control opcode-10 handling.
REQ-030 SHALL keep all other behaviour identical with and without the macro.
REQ-031 SHALL, with FETCH_ILLEGAL_HALT_EN defined, on a load edge where imem_data[7:6]=10: not load ir, leave pc unchanged, set out_valid<=0, halted<=1, state<=HALT.
REQ-032 SHALL, without FETCH_ILLEGAL_HALT_EN, load opcode 10 like any instruction (downstream treats as NOP); halted tied to 0 and HALT unreachable.

Verification
REQ-033 SHALL cover: reset release, out_ready=1, memory 0:06, 1:78, 2:CF -> out_pc 0,1,2 on consecutive cycles; at pc 0 out_op=00, ra=00, rb=01, rd=10.
REQ-034 SHALL cover: out_ready=0 for 3 cycles while presenting pc 1 (0x78) -> out_pc=1, op=01, ra=11, rb=10, rd=00 stable; pc 2 follows one cycle after out_ready=1.
REQ-035 SHALL cover: br_taken=1, br_target=F with out_ready=0 -> next cycle out_valid=0; following cycle out_pc=F, out_valid=1.
REQ-036 SHALL cover: straight-line fetch from pc E with all-zero memory -> out_pc sequence E, F, 0, 1.
REQ-037 SHALL cover: macro defined, memory 3:80 -> after out_pc 2 accepted, halted=1, out_valid=0, imem_addr=3 held; br_taken=1 ignored; rst restores pc=0, halted=0.
REQ-038 SHALL cover: macro undefined, memory 3:80 -> out_pc=3, out_op=10, out_valid=1, halted=0, fetch continues at 4.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: instruction-memory port, decoded-instruction handshake,
// execute-stage redirect and halt status.
interface instruction_fetch_if #(
  parameter int AW = 4,
  parameter int IW = 8
);
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_pc;
  logic [1:0]    out_op;
  logic [1:0]    out_ra;
  logic [1:0]    out_rb;
  logic [1:0]    out_rd;
  logic [AW-1:0] out_target;
  logic          br_taken;
  logic [AW-1:0] br_target;
  logic          halted;

  // Fetch unit side.
  modport master (
    output imem_addr, out_valid, out_pc, out_op, out_ra, out_rb, out_rd,
           out_target, halted,
    input  imem_data, out_ready, br_taken, br_target
  );

  // Memory / downstream / execute side.
  modport slave (
    input  imem_addr, out_valid, out_pc, out_op, out_ra, out_rb, out_rd,
           out_target, halted,
    output imem_data, out_ready, br_taken, br_target
  );
endinterface

// File: rtl/instruction_fetch.sv
// Single-entry fetch stage with valid/ready output, branch redirect and decode.
// Define FETCH_ILLEGAL_HALT_EN to stop fetching on opcode 2'b10.
module instruction_fetch #(
  parameter int AW = 4,
  parameter int IW = 8
) (
  input  logic                clk,
  input  logic                rst,
  instruction_fetch_if.master bus
);

  typedef enum logic {FETCH, HALT} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [AW-1:0] out_pc_q, out_pc_d;
  logic          valid_q, valid_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      out_pc_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      out_pc_q <= out_pc_d;
      valid_q  <= valid_d;
    end
  end

  // NOTE: every signal gets its hold value first, so no path through the
  // case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    out_pc_d = out_pc_q;
    valid_d  = valid_q;
    case (state_q)
      FETCH: begin
        if (bus.br_taken) begin
          // Redirect wins over both stall and load; the slot becomes a bubble.
          pc_d    = bus.br_target;
          valid_d = 1'b0;
        end else if (!valid_q || bus.out_ready) begin
`ifdef FETCH_ILLEGAL_HALT_EN
          if (bus.imem_data[7:6] == 2'b10) begin
            valid_d = 1'b0;
            state_d = HALT;
          end else
`endif
          begin
            ir_d     = bus.imem_data;
            out_pc_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + AW'(1);
          end
        end
      end
      HALT: begin
        valid_d = 1'b0;
      end
    endcase
  end

  assign bus.imem_addr  = pc_q;
  assign bus.out_valid  = valid_q;
  assign bus.out_pc     = out_pc_q;
  assign bus.out_op     = ir_q[7:6];
  assign bus.out_ra     = ir_q[5:4];
  assign bus.out_rb     = ir_q[3:2];
  assign bus.out_rd     = ir_q[1:0];
  assign bus.out_target = ir_q[AW-1:0];

`ifdef FETCH_ILLEGAL_HALT_EN
  assign bus.halted = (state_q == HALT);
`else
  assign bus.halted = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomised and directed bench for instruction_fetch against a
// transaction-level model of the fetch stream.
module tb_instruction_fetch;

  localparam int AW = 4;
  localparam int IW = 8;

`ifdef FETCH_ILLEGAL_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  instruction_fetch_if #(.AW(AW), .IW(IW)) bus ();

  instruction_fetch #(.AW(AW), .IW(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [IW-1:0] mem [16];
  assign bus.imem_data = mem[bus.imem_addr];

  int tests  = 0;
  int failed = 0;

  // Model: next fetch address, the presented instruction and stop flag.
  int unsigned m_pc;
  int unsigned m_ir;
  int unsigned m_out_pc;
  bit          m_valid;
  bit          m_halted;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_ir = 0; m_out_pc = 0; m_valid = 0; m_halted = 0;
  endtask

  // One clock edge of the fetch stream.
  task automatic model_step(input bit rdy, input bit br, input int unsigned tgt);
    int unsigned word;
    if (m_halted) return;
    if (br) begin
      m_pc    = tgt;
      m_valid = 0;
    end else if (!m_valid || rdy) begin
      word = mem[m_pc];
      if (HALT_EN && (word / 64) == 2) begin
        m_valid  = 0;
        m_halted = 1;
      end else begin
        m_ir     = word;
        m_out_pc = m_pc;
        m_valid  = 1;
        m_pc     = (m_pc + 1) % 16;
      end
    end
  endtask

  task automatic compare();
    check("imem_addr", 32'(bus.imem_addr), m_pc);
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("halted", 32'(bus.halted), 32'(m_halted));
    if (m_valid) begin
      check("out_pc", 32'(bus.out_pc), m_out_pc);
      check("out_op", 32'(bus.out_op), (m_ir / 64) % 4);
      check("out_ra", 32'(bus.out_ra), (m_ir / 16) % 4);
      check("out_rb", 32'(bus.out_rb), (m_ir / 4) % 4);
      check("out_rd", 32'(bus.out_rd), m_ir % 4);
      check("out_target", 32'(bus.out_target), m_ir % 16);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input bit rdy, input bit br, input logic [AW-1:0] tgt);
    compare();
    bus.out_ready = rdy;
    bus.br_taken  = br;
    bus.br_target = tgt;
    model_step(rdy, br, tgt);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges, held across one rising edge.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check("rst_imem_addr", 32'(bus.imem_addr), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_halted", 32'(bus.halted), 0);
    check("rst_out_pc", 32'(bus.out_pc), 0);
    bus.out_ready = 1'b0;
    bus.br_taken  = 1'b0;
    bus.br_target = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_basic_program();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0] = 8'h06;
    mem[1] = 8'h78;
    mem[2] = 8'hCF;
    mem[3] = 8'h80;
  endtask

  initial begin
    bus.out_ready = 1'b0;
    bus.br_taken  = 1'b0;
    bus.br_target = '0;
    load_basic_program();
    @(negedge clk);
    do_reset();

    // Straight-line fetch 0,1,2 with downstream always ready.
    cycle(1, 0, 0);
    check("seq0_pc", 32'(bus.out_pc), 0);
    check("seq0_op", 32'(bus.out_op), 0);
    check("seq0_ra", 32'(bus.out_ra), 0);
    check("seq0_rb", 32'(bus.out_rb), 1);
    check("seq0_rd", 32'(bus.out_rd), 2);
    cycle(1, 0, 0);
    check("seq1_pc", 32'(bus.out_pc), 1);
    cycle(1, 0, 0);
    check("seq2_pc", 32'(bus.out_pc), 2);

    // Three-cycle stall while presenting address 1.
    do_reset();
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0);
      check("stall_pc", 32'(bus.out_pc), 1);
      check("stall_op", 32'(bus.out_op), 1);
      check("stall_ra", 32'(bus.out_ra), 3);
      check("stall_rb", 32'(bus.out_rb), 2);
      check("stall_rd", 32'(bus.out_rd), 0);
      check("stall_valid", 32'(bus.out_valid), 1);
    end
    cycle(1, 0, 0);
    check("after_stall_pc", 32'(bus.out_pc), 2);

    // Opcode 10 at address 3.
    cycle(1, 0, 0);
    if (HALT_EN) begin
      check("ill_halted", 32'(bus.halted), 1);
      check("ill_valid", 32'(bus.out_valid), 0);
      check("ill_addr", 32'(bus.imem_addr), 3);
      cycle(1, 1, 4'h9);
      check("halt_br_ignored", 32'(bus.imem_addr), 3);
      check("halt_still", 32'(bus.halted), 1);
      do_reset();
      check("halt_rst_addr", 32'(bus.imem_addr), 0);
      check("halt_rst_halted", 32'(bus.halted), 0);
    end else begin
      check("nop_pc", 32'(bus.out_pc), 3);
      check("nop_op", 32'(bus.out_op), 2);
      check("nop_valid", 32'(bus.out_valid), 1);
      check("nop_halted", 32'(bus.halted), 0);
      cycle(1, 0, 0);
      check("nop_next_pc", 32'(bus.out_pc), 4);
    end

    // Redirect during a stall: one bubble, then the target.
    do_reset();
    cycle(1, 0, 0);
    cycle(0, 1, 4'hF);
    check("redir_bubble", 32'(bus.out_valid), 0);
    cycle(0, 0, 0);
    check("redir_valid", 32'(bus.out_valid), 1);
    check("redir_pc", 32'(bus.out_pc), 15);

    // Wrap from E through F to 0 and 1 over zeroed memory.
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    cycle(1, 1, 4'hE);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0);
      check("wrap_pc", 32'(bus.out_pc), (14 + i) % 16);
    end

    // Randomised traffic against the model.
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 99) == 0 || (m_halted && $urandom_range(0, 7) == 0)) begin
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        do_reset();
      end else begin
        cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
              4'($urandom));
      end
    end
    compare();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
